// File: rtl/operand_shift_loader_pkg.sv
// Shared types and constants for the serial-to-parallel operand loader.
// Provides the FSM state encoding and the beat-counter width helper.
package operand_loader_pkg;

    localparam int DEF_NUM_SRC   = 29;
    localparam int DEF_SRC_WIDTH = 29;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        FULL  = 2'd1,
        FULL2 = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/operand_shift_loader_if.sv
// Beat-input / word-output handshake bundle between a producer and the operand loader.
// The slave modport is the loader's side; master is the producer/consumer side.
interface operand_shift_loader_if
    import operand_loader_pkg::*;
#(
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int SRC_WIDTH = DEF_SRC_WIDTH
);
    logic                         clear;
    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_SRC-1:0]           src_bits;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_SRC*SRC_WIDTH-1:0] src_flat;

    modport master (
        output clear, in_valid, src_bits, out_ready,
        input  in_ready, out_valid, src_flat
    );

    modport slave (
        input  clear, in_valid, src_bits, out_ready,
        output in_ready, out_valid, src_flat
    );
endinterface

// File: rtl/operand_shift_loader_shift_lane.sv
// One operand lane: shifts one serial bit in at the LSB per enabled beat,
// so the first bit received ends up at the MSB. Clear has priority over enable.
module shift_lane #(
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clear,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    if (WIDTH == 1) begin : g_single
        assign w_next = bit_in;
    end else begin : g_multi
        assign w_next = {r_q[WIDTH-2:0], bit_in};
    end

    // NOTE: non-blocking assignment so every lane samples its pre-edge value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clear) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/operand_shift_loader.sv
// Serial-to-parallel operand loader: NUM_SRC lanes, SRC_WIDTH beats per word, valid/ready on both sides.
// Define OPERAND_DOUBLE_BUFFER_EN to add a separate output buffer so shifting continues while a word waits.
module operand_shift_loader
    import operand_loader_pkg::*;
#(
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int SRC_WIDTH = DEF_SRC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_shift_loader_if.slave bus
);
    localparam int CW = cnt_width(SRC_WIDTH);
    localparam int FW = NUM_SRC * SRC_WIDTH;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   w_lanes;
    logic            w_accept;
    logic            w_done;
    logic            w_handshake;

    assign bus.out_valid = (r_state != SHIFT);
`ifdef OPERAND_DOUBLE_BUFFER_EN
    assign bus.in_ready  = (r_state != FULL2);
`else
    assign bus.in_ready  = (r_state == SHIFT);
`endif

    // Clear drops any beat offered in the same cycle.
    assign w_accept    = bus.in_valid && bus.in_ready && !bus.clear;
    assign w_done      = w_accept && (r_cnt == CW'(SRC_WIDTH - 1));
    assign w_handshake = bus.out_valid && bus.out_ready;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        shift_lane #(.WIDTH(SRC_WIDTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (w_accept),
            .bit_in (bus.src_bits[g]),
            .clear  (bus.clear),
            .q      (w_lanes[g*SRC_WIDTH +: SRC_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.clear || w_done) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef OPERAND_DOUBLE_BUFFER_EN
    logic [FW-1:0] r_buf;
    logic [FW-1:0] w_word;

    // Word as it will look after the completing beat, so the buffer loads on that same edge.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_word
        if (SRC_WIDTH == 1) begin : g_w1
            assign w_word[g] = bus.src_bits[g];
        end else begin : g_wn
            assign w_word[g*SRC_WIDTH +: SRC_WIDTH] =
                {w_lanes[g*SRC_WIDTH +: SRC_WIDTH-1], bus.src_bits[g]};
        end
    end

    // FULL: buffer occupied, shift register free. FULL2: both hold a complete word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SHIFT;
            r_buf   <= '0;
        end else if (bus.clear) begin
            r_state <= SHIFT;
            r_buf   <= '0;
        end else begin
            case (r_state)
                SHIFT: if (w_done) begin
                    r_buf   <= w_word;
                    r_state <= FULL;
                end
                FULL: begin
                    if (w_done && w_handshake) begin
                        r_buf <= w_word;
                    end else if (w_done) begin
                        r_state <= FULL2;
                    end else if (w_handshake) begin
                        r_state <= SHIFT;
                    end
                end
                FULL2: if (w_handshake) begin
                    r_buf   <= w_lanes;
                    r_state <= FULL;
                end
                default: r_state <= SHIFT;
            endcase
        end
    end

    assign bus.src_flat = r_buf;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SHIFT;
        end else if (bus.clear) begin
            r_state <= SHIFT;
        end else begin
            case (r_state)
                SHIFT:   if (w_done)      r_state <= FULL;
                FULL:    if (w_handshake) r_state <= SHIFT;
                default: r_state <= SHIFT;
            endcase
        end
    end

    // Lanes cannot shift while FULL, so they are the stable output word.
    assign bus.src_flat = w_lanes;
`endif
endmodule
